// File: rtl/uart_word_axi_writer_if.sv
// AXI4 write-only master bundle between the word writer and DDR3.
// Ports: AW/W/B channel signals; master drives AW/W and bready.
interface uart_word_axi_writer_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] m_awaddr;
   logic              m_awvalid;
   logic              m_awready;
   logic [7:0]        m_awlen;
   logic [2:0]        m_awsize;
   logic [1:0]        m_awburst;
   logic [31:0]       m_wdata;
   logic [3:0]        m_wstrb;
   logic              m_wlast;
   logic              m_wvalid;
   logic              m_wready;
   logic [1:0]        m_bresp;
   logic              m_bvalid;
   logic              m_bready;

   modport master (
      output m_awaddr, m_awvalid, m_awlen, m_awsize, m_awburst,
      output m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
      input  m_awready, m_wready, m_bresp, m_bvalid
   );

   modport slave (
      input  m_awaddr, m_awvalid, m_awlen, m_awsize, m_awburst,
      input  m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
      output m_awready, m_wready, m_bresp, m_bvalid
   );
endinterface

// File: rtl/uart_word_axi_writer.sv
// Collects packed UART words and writes each one to DDR3 over AXI4.
// Ports: axi_clk/rst, packer i_count/i_word/o_trig, AXI master m, status.
module uart_word_axi_writer #(
   parameter int                ADDR_W         = 32,
   parameter logic [ADDR_W-1:0] ADDR_BASE      = '0,
   parameter logic [ADDR_W-1:0] REGION_BYTES   = ADDR_W'(32'h0010_0000),
   parameter int                BYTES_PER_WORD = 4
) (
   input  logic        axi_clk,
   input  logic        rst,
   input  logic        i_count,
   input  logic [31:0] i_word,
   output logic        o_trig,
   uart_word_axi_writer_if.master m,
   output logic [31:0] o_words_written,
   output logic        o_err
);
   typedef enum logic [1:0] {COLLECT, ISSUE, WAIT_B} state_t;

   localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);
   localparam logic [ADDR_W-1:0] END_ADDR = ADDR_BASE + REGION_BYTES;

   state_t            state_q, state_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic              count_q;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              bready_q, bready_d;
   logic [31:0]       words_q, words_d;
   logic              err_q, err_d;

   logic              byte_evt, last_evt, aw_hs, w_hs;
   logic [ADDR_W-1:0] addr_inc;

   assign byte_evt = i_count & ~count_q;
   assign last_evt = byte_evt & (byte_cnt_q == LAST);
   assign aw_hs    = awvalid_q & m.m_awready;
   assign w_hs     = wvalid_q & m.m_wready;
   assign addr_inc = awaddr_q + ADDR_W'(4);

   // Mask the final byte so the packer cannot start a read into a
   // word that is about to be captured.
   assign o_trig = (state_q == COLLECT) & ~last_evt;

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      awvalid_d  = awvalid_q;
      wvalid_d   = wvalid_q;
      bready_d   = bready_q;
      words_d    = words_q;
      err_d      = err_q;
      unique case (state_q)
         COLLECT: begin
            if (last_evt) begin
               wdata_d    = i_word;
               byte_cnt_d = '0;
               awvalid_d  = 1'b1;
               wvalid_d   = 1'b1;
               state_d    = ISSUE;
            end else if (byte_evt) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
            end
         end
         ISSUE: begin
            if (aw_hs) awvalid_d = 1'b0;
            if (w_hs)  wvalid_d  = 1'b0;
            // A channel is done once its valid has dropped or it
            // handshakes this cycle.
            if ((~awvalid_q | aw_hs) & (~wvalid_q | w_hs)) begin
               bready_d = 1'b1;
               state_d  = WAIT_B;
            end
         end
         WAIT_B: begin
            if (bready_q & m.m_bvalid) begin
               bready_d = 1'b0;
               words_d  = words_q + 32'd1;
               err_d    = err_q | (m.m_bresp != 2'b00);
               awaddr_d = (addr_inc == END_ADDR) ? ADDR_BASE : addr_inc;
               state_d  = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge axi_clk) begin
      count_q <= i_count;
      if (!rst) begin
         state_q    <= COLLECT;
         byte_cnt_q <= '0;
         count_q    <= 1'b0;
         awaddr_q   <= ADDR_BASE;
         wdata_q    <= '0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         bready_q   <= 1'b0;
         words_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         awvalid_q  <= awvalid_d;
         wvalid_q   <= wvalid_d;
         bready_q   <= bready_d;
         words_q    <= words_d;
         err_q      <= err_d;
      end
   end

   assign m.m_awaddr  = awaddr_q;
   assign m.m_awvalid = awvalid_q;
   assign m.m_awlen   = 8'd0;
   assign m.m_awsize  = 3'b010;
   assign m.m_awburst = 2'b01;
   assign m.m_wdata   = wdata_q;
   assign m.m_wstrb   = 4'hF;
   assign m.m_wlast   = 1'b1;
   assign m.m_wvalid  = wvalid_q;
   assign m.m_bready  = bready_q;

   assign o_words_written = words_q;
   assign o_err           = err_q;
endmodule

// File: tb/tb_uart_word_axi_writer.sv
// Randomized bench for uart_word_axi_writer with a word/address model.
// Drives the packer side and a reactive AXI slave; checks everything.
module tb_uart_word_axi_writer;
   localparam logic [31:0] BASE   = 32'h0000_0100;
   localparam logic [31:0] REGION = 32'd16;

   logic        axi_clk = 1'b0;
   logic        rst;
   logic        i_count;
   logic [31:0] i_word;
   logic        o_trig;
   logic [31:0] o_words_written;
   logic        o_err;

   uart_word_axi_writer_if #(.ADDR_W(32)) axi ();

   uart_word_axi_writer #(
      .ADDR_W(32),
      .ADDR_BASE(BASE),
      .REGION_BYTES(REGION),
      .BYTES_PER_WORD(4)
   ) dut (
      .axi_clk(axi_clk),
      .rst(rst),
      .i_count(i_count),
      .i_word(i_word),
      .o_trig(o_trig),
      .m(axi.master),
      .o_words_written(o_words_written),
      .o_err(o_err)
   );

   always #5 axi_clk = ~axi_clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // model state
   logic [31:0] exp_words[$];
   int          aw_idx, w_idx, b_cnt;
   logic        err_m;
   logic        b_fire;
   int          stall, bwait;
   int          mode;
   bit          slave_en, model_clr;

   function automatic logic [31:0] exp_addr(input int idx);
      return BASE + ((32'(idx) * 32'd4) % REGION);
   endfunction

   // reactive slave plus monitor
   initial begin
      axi.m_awready = 1'b0;
      axi.m_wready  = 1'b0;
      axi.m_bvalid  = 1'b0;
      axi.m_bresp   = 2'b00;
      aw_idx = 0; w_idx = 0; b_cnt = 0; err_m = 1'b0;
      b_fire = 1'b0; stall = 0; bwait = 0;
      forever begin
         @(negedge axi_clk);
         if (b_fire) begin
            b_fire       = 1'b0;
            axi.m_bvalid = 1'b0;
            chk("words_written", o_words_written, 32'(b_cnt));
            chk("err_sticky", {31'd0, o_err}, {31'd0, err_m});
         end
         if (model_clr) begin
            aw_idx = 0; w_idx = 0; b_cnt = 0; err_m = 1'b0;
         end
         if (!slave_en) begin
            axi.m_awready = 1'b0;
            axi.m_wready  = 1'b0;
            axi.m_bvalid  = 1'b0;
            stall = 0;
            bwait = 0;
         end else begin
            if (mode == 1) begin
               axi.m_awready = 1'b1;
               axi.m_wready  = 1'b1;
            end else if (mode == 2) begin
               axi.m_wready = 1'b1;
               if (axi.m_awvalid && stall < 5) begin
                  axi.m_awready = 1'b0;
                  stall++;
               end else begin
                  axi.m_awready = 1'b1;
               end
            end else begin
               axi.m_awready = ($urandom_range(0, 2) != 0);
               axi.m_wready  = ($urandom_range(0, 2) != 0);
            end
            if (axi.m_bready && !axi.m_bvalid) begin
               if ((mode != 0 && bwait >= 1) ||
                   (mode == 0 && $urandom_range(0, 2) == 0)) begin
                  axi.m_bvalid = 1'b1;
                  bwait = 0;
                  if (b_cnt == 1)
                     axi.m_bresp = 2'b10;
                  else if ($urandom_range(0, 9) == 0)
                     axi.m_bresp = 2'($urandom_range(1, 3));
                  else
                     axi.m_bresp = 2'b00;
               end else begin
                  bwait++;
               end
            end
         end
         #1;
         if (axi.m_awvalid || axi.m_wvalid || axi.m_bready)
            chk("trig_busy", {31'd0, o_trig}, 32'd0);
         if (axi.m_bready) begin
            chk("b_after_aw", 32'(aw_idx), 32'(b_cnt + 1));
            chk("b_after_w", 32'(w_idx), 32'(b_cnt + 1));
         end
         if (axi.m_awvalid) begin
            chk("awaddr", axi.m_awaddr, exp_addr(aw_idx));
            chk("aw_attr", {19'd0, axi.m_awlen, axi.m_awsize,
                            axi.m_awburst},
                {19'd0, 8'd0, 3'b010, 2'b01});
            if (axi.m_awready) begin
               aw_idx++;
               stall = 0;
            end
         end
         if (axi.m_wvalid) begin
            if (w_idx < exp_words.size())
               chk("wdata", axi.m_wdata, exp_words[w_idx]);
            else
               chk("w_extra", 32'(w_idx), 32'(exp_words.size() - 1));
            chk("wstrb_wlast", {27'd0, axi.m_wstrb, axi.m_wlast},
                {27'd0, 4'hF, 1'b1});
            if (axi.m_wready) w_idx++;
         end
         if (axi.m_bvalid && axi.m_bready) begin
            b_cnt++;
            err_m  = err_m | (axi.m_bresp != 2'b00);
            b_fire = 1'b1;
         end
      end
   end

   task automatic wait_trig(output int n);
      n = 0;
      do begin
         @(negedge axi_clk);
         #2;
         n++;
      end while (!o_trig && n < 300);
      if (!o_trig) chk("trig_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_word(input logic [31:0] w, input bit lat_chk,
                            input bit stop_issue);
      int n;
      int hold;
      for (int b = 0; b < 4; b++) begin
         wait_trig(n);
         @(negedge axi_clk);
         i_count = 1'b1;
         if (b == 3) begin
            i_word = w;
            exp_words.push_back(w);
         end else begin
            i_word = $urandom;
         end
         #2;
         chk("trig_mask", {31'd0, o_trig}, (b == 3) ? 32'd0 : 32'd1);
         if (b < 3) begin
            hold = (b == 1) ? 10 : $urandom_range(1, 4);
            repeat (hold) @(negedge axi_clk);
            i_count = 1'b0;
         end
      end
      @(negedge axi_clk);
      #2;
      chk("issue_latency", {30'd0, axi.m_awvalid, axi.m_wvalid}, 32'd3);
      if (stop_issue) return;
      n = 1;
      while (!o_trig && n < 300) begin
         @(negedge axi_clk);
         #2;
         n++;
      end
      if (!o_trig) chk("done_timeout", 32'd0, 32'd1);
      if (lat_chk) chk("trig_latency", 32'(n), 32'd4);
      i_count = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      i_count = 1'b0;
      i_word = '0;
      slave_en = 1'b0;
      model_clr = 1'b1;
      mode = 0;
      repeat (3) @(negedge axi_clk);
      #2;
      chk("rst_valids", {29'd0, axi.m_awvalid, axi.m_wvalid,
                         axi.m_bready}, 32'd0);
      chk("rst_awaddr", axi.m_awaddr, BASE);
      chk("rst_wdata", axi.m_wdata, 32'd0);
      chk("rst_words", o_words_written, 32'd0);
      chk("rst_err", {31'd0, o_err}, 32'd0);
      chk("rst_trig", {31'd0, o_trig}, 32'd1);
      rst = 1'b1;
      model_clr = 1'b0;
      slave_en = 1'b1;

      mode = 1;
      send_word(32'hDEADBEEF, 1'b1, 1'b0);
      mode = 2;
      send_word($urandom, 1'b0, 1'b0);
      mode = 0;
      for (int k = 0; k < 10; k++) send_word($urandom, 1'b0, 1'b0);
      repeat (2) @(negedge axi_clk);

      slave_en = 1'b0;
      repeat (2) @(negedge axi_clk);
      send_word($urandom, 1'b0, 1'b1);
      @(negedge axi_clk);
      rst = 1'b0;
      i_count = 1'b0;
      model_clr = 1'b1;
      @(negedge axi_clk);
      #2;
      chk("mid_rst_valids", {29'd0, axi.m_awvalid, axi.m_wvalid,
                             axi.m_bready}, 32'd0);
      chk("mid_rst_awaddr", axi.m_awaddr, BASE);
      chk("mid_rst_words", o_words_written, 32'd0);
      chk("mid_rst_err", {31'd0, o_err}, 32'd0);
      chk("mid_rst_trig", {31'd0, o_trig}, 32'd1);
      rst = 1'b1;
      exp_words.delete();
      @(negedge axi_clk);
      model_clr = 1'b0;
      slave_en = 1'b1;
      mode = 0;
      for (int k = 0; k < 3; k++) send_word($urandom, 1'b0, 1'b0);
      repeat (3) @(negedge axi_clk);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_word_axi_writer.md
Name: uart_word_axi_writer

Overview:
- Sits directly downstream of the UART byte-packing FSM, which shifts FIFO bytes into a 32-bit word and raises a "byte shifted" level flag.
- Counts completed byte shifts and, after BYTES_PER_WORD bytes, captures the packed word.
- Issues the word as a single-beat AXI4 write to DDR3 at a linearly incrementing, wrapping address.
- Drives the upstream trigger low while a write is pending, so the packer never overruns an unwritten word.

Parameters:
- ADDR_W, 32, AXI address width.
- ADDR_BASE, 32'h0000_0000, first write address; must be 4-byte aligned.
- REGION_BYTES, 32'h0010_0000, size of the write region in bytes; a multiple of 4.
- BYTES_PER_WORD, 4, number of packer byte shifts per AXI word (legal range 1..4).

Ports:
- axi_clk  in  1  clock.
- rst  in  1  reset (synchronous, active-low).
- i_count  in  1  packer byte-shifted flag (level; a new byte is marked by its rising edge).
- i_word  in  32  packer shift register output; valid in the cycle i_count rises.
- o_trig  out  1  enable to the packer; low means the packer must not start another byte.
- m_awaddr  out  ADDR_W  AXI write address.
- m_awvalid  out  1  AXI AW valid.
- m_awready  in  1  AXI AW ready.
- m_awlen/m_awsize/m_awburst  out  8/3/2  tied to 0 / 3'b010 / 2'b01.
- m_wdata  out  32  AXI write data.
- m_wstrb  out  4  tied to 4'hF.
- m_wlast  out  1  tied to 1.
- m_wvalid  out  1  AXI W valid.
- m_wready  in  1  AXI W ready.
- m_bresp  in  2  AXI write response.
- m_bvalid  in  1  AXI B valid.
- m_bready  out  1  AXI B ready.
- o_words_written  out  32  count of completed B handshakes (wraps at 2^32).
- o_err  out  1  sticky: set on any bresp != 2'b00.

Behaviour:
- Reset (rst==0 at an axi_clk edge):
  - state=COLLECT, byte_cnt=0, count_d=0, m_awaddr=ADDR_BASE, m_wdata=0.
  - m_awvalid=m_wvalid=m_bready=0, o_words_written=0, o_err=0.
  - o_trig follows its combinational rule, so it is 1 in the first cycle after reset.
- Reset mid-transaction abandons the transaction without waiting for AXI completion; the system resets the interconnect together with this block.
- Edge detect: count_d <= i_count every cycle; byte_evt = i_count & ~count_d.
- State COLLECT:
  - On byte_evt with byte_cnt < BYTES_PER_WORD-1: byte_cnt++.
  - On byte_evt with byte_cnt == BYTES_PER_WORD-1: m_wdata <= i_word, byte_cnt <= 0, m_awvalid <= 1, m_wvalid <= 1, go to ISSUE.
- State ISSUE:
  - m_awvalid clears on the cycle after its own handshake (awvalid & awready).
  - m_wvalid clears on the cycle after its own handshake (wvalid & wready).
  - The two channels are independent: either may complete first, or both in the same cycle.
  - When both handshakes are complete, including the case where the last one completes this cycle: m_bready <= 1, go to WAIT_B.
  - m_awaddr and m_wdata are held stable while the corresponding valid is high.
- State WAIT_B:
  - On bvalid & bready: m_bready <= 0, o_words_written++, o_err |= (bresp != 0).
  - Address advance: m_awaddr <= m_awaddr+4, or ADDR_BASE if m_awaddr+4 == ADDR_BASE+REGION_BYTES.
  - Go to COLLECT.
- o_trig (combinational) = (state==COLLECT) & ~(byte_evt & byte_cnt==BYTES_PER_WORD-1).
  - Because of the mask, the packer sees trig low in the same cycle it flags the final byte and cannot begin another read.
- byte_evt outside COLLECT is ignored and does not change byte_cnt. It cannot legally occur because o_trig is low in ISSUE and WAIT_B.
- Latency:
  - Final byte rising edge -> awvalid/wvalid high: 1 cycle.
  - Zero-wait slave: B handshake at cycle+3; o_trig high again at cycle+4.
- Exactly one outstanding AXI write at any time; no bursts.

Test Plan:
- Reset, then 4 i_count rising edges with i_word=32'hDEADBEEF on the 4th, awready=wready=1, bvalid one cycle after bready -> one write with awaddr=ADDR_BASE, wdata=32'hDEADBEEF, wstrb=4'hF; o_words_written=1; o_trig low from the 4th-edge cycle through WAIT_B.
- awready held 0 for 5 cycles while wready=1 -> wvalid drops after 1 cycle; awvalid and awaddr stay stable for 5 cycles; bready rises only after the AW handshake.
- i_count held high for 10 cycles between edges -> counted as one byte only; the word is issued after exactly 4 rising edges.
- REGION_BYTES=16, 5 words written -> awaddr sequence base, +4, +8, +12, base.
- bresp=2'b10 on word 2, 2'b00 on word 3 -> o_err=1 after word 2 and stays 1; o_words_written=3.
- rst low while in ISSUE with awvalid=1 -> next cycle awvalid=wvalid=bready=0, awaddr=ADDR_BASE, counters 0, o_trig=1.
